// File: rtl/fd_pkg.sv
// rtl/fd_pkg.sv - opcodes, instruction field positions and control bundle for the front end
package fd_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_LW  = 2'b01;
  localparam logic [1:0] OP_SW  = 2'b10;
  localparam logic [1:0] OP_J   = 2'b11;

  // Field map of the fixed 8-bit instruction word
  localparam int OP_MSB    = 7;
  localparam int OP_LSB    = 6;
  localparam int RS_MSB    = 5;
  localparam int RS_LSB    = 4;
  localparam int RT_MSB    = 3;
  localparam int RT_LSB    = 2;
  localparam int RD_MSB    = 1;
  localparam int RD_LSB    = 0;
  localparam int JADDR_MSB = 5;
  localparam int JADDR_W   = 6;

  typedef struct packed {
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic alu_src;
    logic reg_dst;
    logic jump;
  } ctrl_t;

  localparam ctrl_t CTRL_NONE = '0;

  // Main-control truth table, one entry per opcode
  function automatic ctrl_t op_to_ctrl(input logic [1:0] op);
    ctrl_t c;
    c = CTRL_NONE;
    case (op)
      OP_ADD: begin c.reg_write = 1'b1; c.reg_dst = 1'b1; end
      OP_LW:  begin c.reg_write = 1'b1; c.mem_read = 1'b1; c.alu_src = 1'b1; end
      OP_SW:  begin c.mem_write = 1'b1; c.alu_src = 1'b1; end
      default: c.jump = 1'b1;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/instr_field_decode.sv
// rtl/instr_field_decode.sv - combinational split of an instruction word into fields and controls
module instr_field_decode
  import fd_pkg::*;
(
  input  logic [7:0]         i_instr,
  output logic [1:0]         o_opcode,
  output logic [1:0]         o_rs,
  output logic [1:0]         o_rt,
  output logic [1:0]         o_rd,
  output logic [1:0]         o_imm,
  output logic [JADDR_W-1:0] o_jaddr,
  output ctrl_t              o_ctrl
);

  assign o_opcode = i_instr[OP_MSB:OP_LSB];
  assign o_rs     = i_instr[RS_MSB:RS_LSB];
  assign o_rt     = i_instr[RT_MSB:RT_LSB];
  assign o_rd     = i_instr[RD_MSB:RD_LSB];
  // The immediate shares bits with rd; it goes out raw to the sign extender
  assign o_imm    = i_instr[RD_MSB:RD_LSB];
  assign o_jaddr  = i_instr[JADDR_MSB:0];
  assign o_ctrl   = op_to_ctrl(i_instr[OP_MSB:OP_LSB]);

endmodule

// File: rtl/fetch_decode_unit.sv
// rtl/fetch_decode_unit.sv - PC, ROM fetch tracking and registered decode with one-bubble jumps
module fetch_decode_unit
  import fd_pkg::*;
#(
  parameter int PC_W    = 8,
  parameter int INSTR_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               stall,
  output logic               dec_valid,
  output logic [PC_W-1:0]    dec_pc,
  output logic [1:0]         opcode,
  output logic [1:0]         rs,
  output logic [1:0]         rt,
  output logic [1:0]         rd,
  output logic [1:0]         imm,
  output logic [5:0]         jaddr,
  output logic               reg_write,
  output logic               mem_read,
  output logic               mem_write,
  output logic               alu_src,
  output logic               reg_dst,
  output logic               jump
);

  logic [PC_W-1:0]    r_pc;
  logic [PC_W-1:0]    r_f_pc;
  logic               r_f_valid;

  logic               r_dec_valid;
  logic [PC_W-1:0]    r_dec_pc;
  logic [1:0]         r_opcode;
  logic [1:0]         r_rs;
  logic [1:0]         r_rt;
  logic [1:0]         r_rd;
  logic [1:0]         r_imm;
  logic [JADDR_W-1:0] r_jaddr;
  ctrl_t              r_ctrl;

  logic [1:0]         w_opcode;
  logic [1:0]         w_rs;
  logic [1:0]         w_rt;
  logic [1:0]         w_rd;
  logic [1:0]         w_imm;
  logic [JADDR_W-1:0] w_jaddr;
  ctrl_t              w_ctrl;
  ctrl_t              w_ctrl_gated;
  logic               w_take_jump;
  logic [PC_W-1:0]    w_jtarget;

  instr_field_decode u_decode (
    .i_instr  (imem_rdata),
    .o_opcode (w_opcode),
    .o_rs     (w_rs),
    .o_rt     (w_rt),
    .o_rd     (w_rd),
    .o_imm    (w_imm),
    .o_jaddr  (w_jaddr),
    .o_ctrl   (w_ctrl)
  );

  // A squashed word must neither redirect nor raise any control bit
  assign w_ctrl_gated = r_f_valid ? w_ctrl : CTRL_NONE;
  assign w_take_jump  = r_f_valid && !stall && (w_opcode == OP_J);
  assign w_jtarget    = PC_W'(w_jaddr);

  // While stalled, re-present the word already on the bus so nothing is lost
  assign imem_addr = stall ? r_f_pc : r_pc;

  // Fetch side: advance the PC, or redirect and squash the in-flight sequential fetch
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc      <= '0;
      r_f_pc    <= '0;
      r_f_valid <= 1'b0;
    end else if (!stall) begin
      r_f_pc <= r_pc;
      if (w_take_jump) begin
        r_pc      <= w_jtarget;
        r_f_valid <= 1'b0;
      end else begin
        r_pc      <= r_pc + PC_W'(1);
        r_f_valid <= 1'b1;
      end
    end
  end

  // Decode register: capture the ROM word and its address each unstalled cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_dec_valid <= 1'b0;
      r_dec_pc    <= '0;
      r_opcode    <= '0;
      r_rs        <= '0;
      r_rt        <= '0;
      r_rd        <= '0;
      r_imm       <= '0;
      r_jaddr     <= '0;
      r_ctrl      <= CTRL_NONE;
    end else if (!stall) begin
      r_dec_valid <= r_f_valid;
      r_dec_pc    <= r_f_pc;
      r_opcode    <= w_opcode;
      r_rs        <= w_rs;
      r_rt        <= w_rt;
      r_rd        <= w_rd;
      r_imm       <= w_imm;
      r_jaddr     <= w_jaddr;
      r_ctrl      <= w_ctrl_gated;
    end
  end

  assign dec_valid = r_dec_valid;
  assign dec_pc    = r_dec_pc;
  assign opcode    = r_opcode;
  assign rs        = r_rs;
  assign rt        = r_rt;
  assign rd        = r_rd;
  assign imm       = r_imm;
  assign jaddr     = r_jaddr;
  assign reg_write = r_ctrl.reg_write;
  assign mem_read  = r_ctrl.mem_read;
  assign mem_write = r_ctrl.mem_write;
  assign alu_src   = r_ctrl.alu_src;
  assign reg_dst   = r_ctrl.reg_dst;
  assign jump      = r_ctrl.jump;

endmodule

// File: tb/tb_fetch_decode_unit.sv
// tb/tb_fetch_decode_unit.sv - directed self-checking bench for fetch_decode_unit
module tb_fetch_decode_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic       stall;
  logic [7:0] imem_addr;
  logic [7:0] imem_rdata;
  logic       dec_valid;
  logic [7:0] dec_pc;
  logic [1:0] opcode, rs, rt, rd, imm;
  logic [5:0] jaddr;
  logic       reg_write, mem_read, mem_write, alu_src, reg_dst, jump;

  logic [7:0] rom [0:255];
  int n_checks = 0;
  int n_fail = 0;

  fetch_decode_unit #(.PC_W(8), .INSTR_W(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .stall      (stall),
    .dec_valid  (dec_valid),
    .dec_pc     (dec_pc),
    .opcode     (opcode),
    .rs         (rs),
    .rt         (rt),
    .rd         (rd),
    .imm        (imm),
    .jaddr      (jaddr),
    .reg_write  (reg_write),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .alu_src    (alu_src),
    .reg_dst    (reg_dst),
    .jump       (jump)
  );

  always #5 clk = ~clk;

  // Synchronous ROM: data valid one cycle after the address
  always @(posedge clk) imem_rdata <= rom[imem_addr];

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 8'h00;
    rom[0]    = 8'h1B;
    rom[1]    = 8'h56;
    rom[2]    = 8'h9E;
    rom[3]    = 8'h07;
    rom[4]    = 8'hE8;
    rom[5]    = 8'h55;
    rom[8'h28] = 8'h6C;

    reset = 1'b1;
    stall = 1'b0;
    tick();
    tick();
    check("rst_dec_valid", 16'(dec_valid), 16'h0);
    check("rst_dec_pc", 16'(dec_pc), 16'h0);
    check("rst_imem_addr", 16'(imem_addr), 16'h0);
    check("rst_reg_write", 16'(reg_write), 16'h0);
    check("rst_reg_dst", 16'(reg_dst), 16'h0);
    reset = 1'b0;

    // T1: first decode two edges after release
    tick();
    check("t1_edge1_not_valid", 16'(dec_valid), 16'h0);
    check("t1_edge1_addr", 16'(imem_addr), 16'h1);
    tick();
    check("t1_valid", 16'(dec_valid), 16'h1);
    check("t1_pc", 16'(dec_pc), 16'h0);
    check("t1_opcode", 16'(opcode), 16'h0);
    check("t1_rs", 16'(rs), 16'h1);
    check("t1_rt", 16'(rt), 16'h2);
    check("t1_rd", 16'(rd), 16'h3);
    check("t1_reg_write", 16'(reg_write), 16'h1);
    check("t1_reg_dst", 16'(reg_dst), 16'h1);
    check("t1_mem_read", 16'(mem_read), 16'h0);

    // T2: lw then sw
    tick();
    check("t2_lw_pc", 16'(dec_pc), 16'h1);
    check("t2_lw_mem_read", 16'(mem_read), 16'h1);
    check("t2_lw_alu_src", 16'(alu_src), 16'h1);
    check("t2_lw_imm", 16'(imm), 16'h2);
    check("t2_lw_reg_dst", 16'(reg_dst), 16'h0);
    tick();
    check("t2_sw_pc", 16'(dec_pc), 16'h2);
    check("t2_sw_mem_write", 16'(mem_write), 16'h1);
    check("t2_sw_reg_write", 16'(reg_write), 16'h0);

    // T4: stall three cycles with dec_pc=2
    stall = 1'b1;
    #1;
    check("t4_addr_fpc", 16'(imem_addr), 16'h3);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("t4_hold_pc", 16'(dec_pc), 16'h2);
      check("t4_hold_mem_write", 16'(mem_write), 16'h1);
      check("t4_hold_addr", 16'(imem_addr), 16'h3);
    end
    stall = 1'b0;
    tick();
    check("t4_after_pc3", 16'(dec_pc), 16'h3);
    check("t4_after_rd", 16'(rd), 16'h3);
    check("t4_after_rt", 16'(rt), 16'h1);

    // T3: jump at 4 to 0x28 with one bubble
    tick();
    check("t3_jump", 16'(jump), 16'h1);
    check("t3_jump_pc", 16'(dec_pc), 16'h4);
    check("t3_jaddr", 16'(jaddr), 16'h28);
    check("t3_jump_valid", 16'(dec_valid), 16'h1);
    check("t3_jump_reg_write", 16'(reg_write), 16'h0);
    check("t3_target_addr", 16'(imem_addr), 16'h28);
    tick();
    check("t3_bubble_valid", 16'(dec_valid), 16'h0);
    check("t3_bubble_reg_write", 16'(reg_write), 16'h0);
    check("t3_bubble_mem_read", 16'(mem_read), 16'h0);
    tick();
    check("t3_target_pc", 16'(dec_pc), 16'h28);
    check("t3_target_valid", 16'(dec_valid), 16'h1);
    check("t3_target_opcode", 16'(opcode), 16'h1);
    check("t3_target_mem_read", 16'(mem_read), 16'h1);

    // T6: run sequentially up to the wrap point
    repeat (214) tick();
    check("t6_pc_fe", 16'(dec_pc), 16'hFE);
    check("t6_fe_valid", 16'(dec_valid), 16'h1);
    tick();
    check("t6_pc_ff", 16'(dec_pc), 16'hFF);
    tick();
    check("t6_pc_00", 16'(dec_pc), 16'h00);
    check("t6_00_rs", 16'(rs), 16'h1);
    tick();
    tick();
    tick();
    check("t5_pre_pc3", 16'(dec_pc), 16'h3);

    // T5: stall while the jump word is on the ROM bus
    stall = 1'b1;
    for (int k = 0; k < 2; k++) begin
      tick();
      check("t5_hold_pc", 16'(dec_pc), 16'h3);
      check("t5_no_jump", 16'(jump), 16'h0);
      check("t5_addr", 16'(imem_addr), 16'h4);
    end
    stall = 1'b0;
    tick();
    check("t5_jump", 16'(jump), 16'h1);
    check("t5_jump_pc", 16'(dec_pc), 16'h4);
    tick();
    check("t5_bubble", 16'(dec_valid), 16'h0);
    tick();
    check("t5_target_pc", 16'(dec_pc), 16'h28);
    tick();
    tick();
    check("t6_run_pc", 16'(dec_pc), 16'h2A);

    // T6: asynchronous reset mid-cycle
    #1;
    reset = 1'b1;
    #1;
    check("t6_async_valid", 16'(dec_valid), 16'h0);
    check("t6_async_pc", 16'(dec_pc), 16'h0);
    check("t6_async_addr", 16'(imem_addr), 16'h0);
    check("t6_async_reg_write", 16'(reg_write), 16'h0);
    tick();
    reset = 1'b0;
    tick();
    check("t6_restart_edge1", 16'(dec_valid), 16'h0);
    tick();
    check("t6_restart_valid", 16'(dec_valid), 16'h1);
    check("t6_restart_pc", 16'(dec_pc), 16'h0);
    check("t6_restart_rs", 16'(rs), 16'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
